rob_param: RTL and testbench
============================

Name: rob_param

Overview:
Parametrised reorder buffer, the successor of the fixed 16-entry ROB. It sits between dispatch (push), the execution units (write-back ports) and the register file/commit logic (commit port).
- Depth, data width and number of write-back ports are generalised.
- Write-back is tag-indexed rather than searched, and a count register replaces the wasted-slot full test.
- The commit port adds a valid/ready handshake; a misprediction flush is retained.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
IDX_W, $clog2(DEPTH), slot index width
TAG_W, $clog2(DEPTH+1), tag width; tag = slot index + 1, 0 = none
XLEN, 32, value/address width
WB_PORTS, 2, number of write-back ports (port 0 = RS, port 1 = LSB)

Ports:
clk_in  in  1  clock, rising edge
rst_n_in  in  1  reset, asynchronous, active-low
rdy_in  in  1  global enable; low = hold all state
flush  in  1  misprediction clear
push_valid  in  1  dispatch request
push_rd_idx  in  5  destination register
push_src_addr  in  XLEN  instruction PC
push_tag  out  TAG_W  tag the next accepted push receives (rear+1); 0 when full
rob_full  out  1  count == DEPTH
rob_empty  out  1  count == 0
count  out  TAG_W  occupied entries
wb_valid  in  WB_PORTS  per-port write-back strobe
wb_tag  in  WB_PORTS*TAG_W  port p at [p*TAG_W +: TAG_W]
wb_val  in  WB_PORTS*XLEN  port p at [p*XLEN +: XLEN]
commit_valid  out  1  head occupied and ready
commit_ready  in  1  consumer accepts head
commit_tag  out  TAG_W  head tag
commit_val  out  XLEN  head value
commit_addr  out  XLEN  head PC
commit_rd_idx  out  5  head rd

Behaviour:
- Entry fields: {busy, ready, rd[4:0], val, addr}. Pointers front and rear are IDX_W bits and wrap naturally (DEPTH is a power of two).
- Reset (async on rst_n_in low):
  - All busy/ready bits = 0; front = rear = count = 0.
  - Outputs: push_tag = 1, rob_full = 0, rob_empty = 1, commit_valid = 0, all commit_* fields = 0.
- rdy_in low: no state change. Outputs keep reflecting held state. A commit handshake is not consumed.
- Cycle priority when rdy_in is high:
  - flush outranks everything: clear all busy/ready; front = rear = count = 0. Push, write-back and commit are ignored that cycle.
- Push: accepted iff push_valid && !rob_full.
  - Slot rear gets busy = 1, ready = 0, rd and addr from the inputs, val = 0. rear increments.
  - rob_full is registered-count based, so a push while full is rejected even if a commit happens the same cycle.
- Write-back, per port p with wb_valid[p]:
  - Tag t = 0 is ignored; otherwise slot = t-1.
  - Applied only if the slot is busy && !ready: set ready = 1, val = wb_val[p].
  - A write-back to a slot being pushed the same cycle is ignored (slot not yet busy).
  - Two ports with the same tag in one cycle: lowest port index wins.
  - Write-back to a non-busy or already-ready slot is a silent no-op.
- Commit:
  - commit_valid = busy[front] && ready[front], combinational from registers.
  - Transfer when commit_valid && commit_ready: clear slot front, front increments.
  - Latency: write-back at edge N makes commit_valid high after edge N, so transfer is possible at edge N+1. No same-cycle bypass from write-back to commit.
  - commit_* fields are 0 when commit_valid = 0.
- count: next = count + push_accepted - commit_fire. Push and commit in the same cycle leave count unchanged.
- In-order commit: a ready younger entry never commits while the head is not ready.

Optional Feature:
ROB_QUERY_EN
- Defined: adds two operand-lookup ports for the rename stage.
  - Ports: qry_tag in 2*TAG_W, qry_ready out 2, qry_val out 2*XLEN.
  - Combinational: qry_ready[k] = busy && ready of slot qry_tag[k]-1; qry_val[k] = that slot's val, else 0.
  - Tag 0 returns ready = 0, val = 0.
  - No same-cycle write-back forwarding.
- Undefined: the ports and logic are absent.

Test Plan (DEPTH=4):
- Reset, then 4 pushes (PC 0x100, 0x104, 0x108, 0x10C) -> push_tag 1,2,3,4; rob_full = 1, count = 4, push_tag = 0; 5th push rejected, count stays 4.
- Write-back tag 2 val 0xAA before tag 1 -> commit_valid stays 0. Write-back tag 1 val 0x55 -> next cycle commit 0x55 then 0xAA, in order, commit_rd_idx matching the pushes.
- Both ports write tag 3 in one cycle (0x11 on port 0, 0x22 on port 1) -> committed value 0x11. Later write-back to tag 3 is ignored.
- Full ROB with head ready, commit_ready = 1 and push_valid = 1 in the same cycle -> push rejected, count = 3. Next cycle push accepted with tag 1 (wrap-around).
- flush with 3 busy entries and a write-back in the same cycle -> next cycle count = 0, rob_empty = 1, push_tag = 1, commit_valid = 0.
- rdy_in low for 3 cycles with commit_valid = 1 and commit_ready = 1 -> no pop, count unchanged. Drop rst_n_in mid-stream -> outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/rob_param.sv
// ---------------------------------------------------------------------------
// rob_param -- parametrised reorder buffer
//
// Sits between dispatch (push), the execution units (write-back ports) and
// the commit logic (commit port). Entries are allocated in program order at
// the rear, completed out of order by tag, and retired in order from the
// front through a valid/ready handshake. A flush discards every entry.
//
// Tags are slot index + 1, so tag 0 means "no entry". Occupancy is held in
// an explicit count register, which lets all DEPTH slots be used.
//
// Optional feature (compile-time macro):
//   ROB_QUERY_EN  adds two combinational operand-lookup ports for rename:
//                 qry_tag (2*TAG_W), qry_ready (2), qry_val (2*XLEN).
//                 Without the macro those ports and their logic are absent.
//
// Ports:
//   clk_in          clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   rdy_in          global enable; low holds all state
//   flush           misprediction clear (outranks everything else)
//   push_valid      dispatch request
//   push_rd_idx     destination register of the pushed instruction
//   push_src_addr   PC of the pushed instruction
//   push_tag        tag the next accepted push receives; 0 when full
//   rob_full        count == DEPTH
//   rob_empty       count == 0
//   count           occupied entries
//   wb_valid        per-port write-back strobe
//   wb_tag          port p tag at [p*TAG_W +: TAG_W]
//   wb_val          port p value at [p*XLEN +: XLEN]
//   commit_valid    head entry occupied and ready
//   commit_ready    consumer accepts the head entry
//   commit_tag      head tag        (0 when commit_valid is low)
//   commit_val      head value      (0 when commit_valid is low)
//   commit_addr     head PC         (0 when commit_valid is low)
//   commit_rd_idx   head rd         (0 when commit_valid is low)
// ---------------------------------------------------------------------------
module rob_param #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int TAG_W    = $clog2(DEPTH + 1),
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush,

    input  logic                      push_valid,
    input  logic [4:0]                push_rd_idx,
    input  logic [XLEN-1:0]           push_src_addr,
    output logic [TAG_W-1:0]          push_tag,
    output logic                      rob_full,
    output logic                      rob_empty,
    output logic [TAG_W-1:0]          count,

    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]  wb_val,

    output logic                      commit_valid,
    input  logic                      commit_ready,
    output logic [TAG_W-1:0]          commit_tag,
    output logic [XLEN-1:0]           commit_val,
    output logic [XLEN-1:0]           commit_addr,
    output logic [4:0]                commit_rd_idx
`ifdef ROB_QUERY_EN
    ,
    input  logic [2*TAG_W-1:0]        qry_tag,
    output logic [1:0]                qry_ready,
    output logic [2*XLEN-1:0]         qry_val
`endif
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] front_q, front_d;
    logic [IDX_W-1:0] rear_q,  rear_d;
    logic [TAG_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] busy_q,  busy_d;
    logic [DEPTH-1:0] ready_q, ready_d;

    // Payload fields carry no reset: they are only observable through
    // busy/ready, which are reset.
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [XLEN-1:0]  val_q  [DEPTH];
    logic [XLEN-1:0]  val_d  [DEPTH];
    logic [XLEN-1:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  addr_d [DEPTH];

    logic             head_ok;
    logic             push_acc;
    logic             commit_fire;

    logic [WB_PORTS-1:0] wb_hit;
    logic [IDX_W-1:0]    wb_slot [WB_PORTS];

    // -----------------------------------------------------------------------
    // Write-back tag decode. Tags outside 1..DEPTH never address a slot, so
    // a stray wide tag cannot alias onto a live entry after truncation.
    // -----------------------------------------------------------------------
    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb
        logic [TAG_W-1:0] tag;
        assign tag        = wb_tag[p*TAG_W +: TAG_W];
        assign wb_hit[p]  = wb_valid[p] && (tag != '0) && (tag <= TAG_W'(DEPTH));
        assign wb_slot[p] = IDX_W'(tag - TAG_W'(1));
    end

    // -----------------------------------------------------------------------
    // Status and handshake
    // -----------------------------------------------------------------------
    assign rob_full    = (count_q == TAG_W'(DEPTH));
    assign rob_empty   = (count_q == '0);
    assign count       = count_q;
    assign head_ok     = busy_q[front_q] && ready_q[front_q];

    // Full is judged on the registered count, so a commit in the same cycle
    // does not open a slot for a push.
    assign push_acc    = push_valid && !rob_full;
    assign commit_fire = head_ok && commit_ready;

    assign push_tag    = rob_full ? '0 : (TAG_W'(rear_q) + TAG_W'(1));

    assign commit_valid  = head_ok;
    assign commit_tag    = head_ok ? (TAG_W'(front_q) + TAG_W'(1)) : '0;
    assign commit_val    = head_ok ? val_q[front_q]  : '0;
    assign commit_addr   = head_ok ? addr_q[front_q] : '0;
    assign commit_rd_idx = head_ok ? rd_q[front_q]   : '0;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        front_d = front_q;
        rear_d  = rear_q;
        count_d = count_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        rd_d    = rd_q;
        val_d   = val_q;
        addr_d  = addr_q;

        if (rdy_in) begin
            if (flush) begin
                busy_d  = '0;
                ready_d = '0;
                front_d = '0;
                rear_d  = '0;
                count_d = '0;
            end else begin
                // Eligibility is tested on registered busy/ready, so a slot
                // being pushed this cycle is not yet writable. Walking the
                // ports from highest to lowest lets the lowest index land
                // last when two ports hit the same slot.
                for (int p = WB_PORTS - 1; p >= 0; p--) begin
                    if (wb_hit[p] && busy_q[wb_slot[p]] && !ready_q[wb_slot[p]]) begin
                        ready_d[wb_slot[p]] = 1'b1;
                        val_d[wb_slot[p]]   = wb_val[p*XLEN +: XLEN];
                    end
                end

                // The rear slot is never busy when a push is accepted, so
                // this cannot collide with the write-back updates above.
                if (push_acc) begin
                    busy_d[rear_q]  = 1'b1;
                    ready_d[rear_q] = 1'b0;
                    rd_d[rear_q]    = push_rd_idx;
                    addr_d[rear_q]  = push_src_addr;
                    val_d[rear_q]   = '0;
                    rear_d          = rear_q + IDX_W'(1);
                end

                // The head is already ready when it fires, so write-back
                // left it untouched; clearing it here is unambiguous.
                if (commit_fire) begin
                    busy_d[front_q]  = 1'b0;
                    ready_d[front_q] = 1'b0;
                    front_d          = front_q + IDX_W'(1);
                end

                count_d = count_q + TAG_W'(push_acc) - TAG_W'(commit_fire);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            front_q <= '0;
            rear_q  <= '0;
            count_q <= '0;
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            front_q <= front_d;
            rear_q  <= rear_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    // -----------------------------------------------------------------------
    // Payload registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        rd_q   <= rd_d;
        val_q  <= val_d;
        addr_q <= addr_d;
    end

`ifdef ROB_QUERY_EN
    // -----------------------------------------------------------------------
    // Operand lookup for rename. Reads registered state only, so a value
    // written back this cycle becomes visible from the next cycle.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_qry
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] slot;
        logic             hit;
        assign tag  = qry_tag[k*TAG_W +: TAG_W];
        assign slot = IDX_W'(tag - TAG_W'(1));
        assign hit  = (tag != '0) && (tag <= TAG_W'(DEPTH)) && busy_q[slot] && ready_q[slot];
        assign qry_ready[k]            = hit;
        assign qry_val[k*XLEN +: XLEN] = hit ? val_q[slot] : '0;
    end
`endif

endmodule

// File: tb/tb_rob_param.sv
`timescale 1ns/1ps
module tb_rob_param;

    localparam int D  = 4;
    localparam int TW = 3;
    localparam int XL = 32;
    localparam int NP = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            rdy = 1'b0;
    logic            flush = 1'b0;
    logic            push_valid = 1'b0;
    logic [4:0]      push_rd_idx = '0;
    logic [XL-1:0]   push_src_addr = '0;
    logic [TW-1:0]   push_tag;
    logic            rob_full;
    logic            rob_empty;
    logic [TW-1:0]   count;
    logic [NP-1:0]   wb_valid = '0;
    logic [NP*TW-1:0] wb_tag = '0;
    logic [NP*XL-1:0] wb_val = '0;
    logic            commit_valid;
    logic            commit_ready = 1'b0;
    logic [TW-1:0]   commit_tag;
    logic [XL-1:0]   commit_val;
    logic [XL-1:0]   commit_addr;
    logic [4:0]      commit_rd_idx;

    rob_param #(.DEPTH(D), .XLEN(XL), .WB_PORTS(NP)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .rdy_in        (rdy),
        .flush         (flush),
        .push_valid    (push_valid),
        .push_rd_idx   (push_rd_idx),
        .push_src_addr (push_src_addr),
        .push_tag      (push_tag),
        .rob_full      (rob_full),
        .rob_empty     (rob_empty),
        .count         (count),
        .wb_valid      (wb_valid),
        .wb_tag        (wb_tag),
        .wb_val        (wb_val),
        .commit_valid  (commit_valid),
        .commit_ready  (commit_ready),
        .commit_tag    (commit_tag),
        .commit_val    (commit_val),
        .commit_addr   (commit_addr),
        .commit_rd_idx (commit_rd_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: the ROB as an ordered queue of in-flight instructions.
    // -----------------------------------------------------------------------
    typedef struct {
        logic [TW-1:0] tag;
        logic [4:0]    rd;
        logic [XL-1:0] addr;
        logic [XL-1:0] val;
        bit            done;
    } ent_t;

    ent_t          mq[$];
    int            next_slot = 0;
    bit            m_fire;
    bit            m_push;
    logic [TW-1:0] m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            next_slot = 0;
        end else if (rdy) begin
            if (flush) begin
                mq.delete();
                next_slot = 0;
            end else begin
                m_fire = (mq.size() > 0) && mq[0].done && commit_ready;
                m_push = push_valid && (mq.size() < D);
                // Lowest port first: once it completes an entry, higher
                // ports see it as done and leave it alone.
                for (int p = 0; p < NP; p++) begin
                    if (wb_valid[p]) begin
                        m_t = wb_tag[p*TW +: TW];
                        foreach (mq[i]) begin
                            if (mq[i].tag == m_t && !mq[i].done) begin
                                mq[i].done = 1'b1;
                                mq[i].val  = wb_val[p*XL +: XL];
                            end
                        end
                    end
                end
                if (m_fire) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back('{tag: TW'(next_slot + 1), rd: push_rd_idx,
                                   addr: push_src_addr, val: '0, done: 1'b0});
                    next_slot = (next_slot + 1) % D;
                end
            end
        end
    end

    // Compare process: outputs depend only on registered state, so checking
    // at the falling edge sees them settled.
    int n;
    always @(negedge clk) begin
        n = mq.size();
        chk("count",     64'(count),     64'(n));
        chk("rob_full",  64'(rob_full),  64'(n == D));
        chk("rob_empty", 64'(rob_empty), 64'(n == 0));
        chk("push_tag",  64'(push_tag),  (n == D) ? 64'd0 : 64'(next_slot + 1));
        if (n > 0 && mq[0].done) begin
            chk("commit_valid",  64'(commit_valid),  64'd1);
            chk("commit_tag",    64'(commit_tag),    64'(mq[0].tag));
            chk("commit_val",    64'(commit_val),    64'(mq[0].val));
            chk("commit_addr",   64'(commit_addr),   64'(mq[0].addr));
            chk("commit_rd_idx", 64'(commit_rd_idx), 64'(mq[0].rd));
        end else begin
            chk("commit_valid",  64'(commit_valid),  64'd0);
            chk("commit_tag",    64'(commit_tag),    64'd0);
            chk("commit_val",    64'(commit_val),    64'd0);
            chk("commit_addr",   64'(commit_addr),   64'd0);
            chk("commit_rd_idx", 64'(commit_rd_idx), 64'd0);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic drive(input int pv, input int rd, input int a, input int wv,
                         input int t0, input int v0, input int t1, input int v1,
                         input int cr);
        push_valid    = pv[0];
        push_rd_idx   = 5'(rd);
        push_src_addr = XL'(a);
        wb_valid      = NP'(wv);
        wb_tag        = {TW'(t1), TW'(t0)};
        wb_val        = {XL'(v1), XL'(v0)};
        commit_ready  = cr[0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outputs(input string tagname);
        chk({tagname, "_count"},    64'(count),        64'd0);
        chk({tagname, "_empty"},    64'(rob_empty),    64'd1);
        chk({tagname, "_full"},     64'(rob_full),     64'd0);
        chk({tagname, "_push_tag"}, 64'(push_tag),     64'd1);
        chk({tagname, "_cvalid"},   64'(commit_valid), 64'd0);
        chk({tagname, "_cval"},     64'(commit_val),   64'd0);
        chk({tagname, "_caddr"},    64'(commit_addr),  64'd0);
    endtask

    initial begin
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Fill: tags 1..4 in order
        for (int i = 0; i < 4; i++) begin
            chk("fill_push_tag", 64'(push_tag), 64'(i + 1));
            drive(1, i + 1, 32'h100 + 4 * i, 0, 0, 0, 0, 0, 0);
        end
        chk("full_flag",  64'(rob_full), 64'd1);
        chk("full_count", 64'(count),    64'd4);
        chk("full_tag",   64'(push_tag), 64'd0);
        drive(1, 9, 32'h200, 0, 0, 0, 0, 0, 0);
        chk("push5_rejected", 64'(count), 64'd4);

        // Younger completes first: head still blocks
        drive(0, 0, 0, 1, 2, 32'hAA, 0, 0, 1);
        chk("ooo_no_commit", 64'(commit_valid), 64'd0);
        drive(0, 0, 0, 1, 1, 32'h55, 0, 0, 0);
        chk("head_valid", 64'(commit_valid),  64'd1);
        chk("head_val",   64'(commit_val),    64'h55);
        chk("head_rd",    64'(commit_rd_idx), 64'd1);
        chk("head_addr",  64'(commit_addr),   64'h100);

        // Full + commit + push in one cycle: push rejected, wrap tag next
        drive(1, 5, 32'h110, 0, 0, 0, 0, 0, 1);
        chk("full_commit_count", 64'(count),        64'd3);
        chk("wrap_push_tag",     64'(push_tag),     64'd1);
        chk("second_val",        64'(commit_val),   64'hAA);
        chk("second_rd",         64'(commit_rd_idx), 64'd2);
        drive(1, 5, 32'h110, 0, 0, 0, 0, 0, 0);
        chk("wrap_push_count", 64'(count), 64'd4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("after_pop_count", 64'(count),        64'd3);
        chk("tag3_not_ready",  64'(commit_valid), 64'd0);

        // Both ports hit tag 3: port 0 wins; later write is ignored
        drive(0, 0, 0, 3, 3, 32'h11, 3, 32'h22, 0);
        chk("dual_tag", 64'(commit_tag), 64'd3);
        chk("dual_val", 64'(commit_val), 64'h11);
        drive(0, 0, 0, 1, 3, 32'h99, 0, 0, 0);
        chk("late_wb_ignored", 64'(commit_val), 64'h11);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("pop3_count", 64'(count), 64'd2);

        // Global hold with a pending handshake
        drive(0, 0, 0, 1, 4, 32'h77, 0, 0, 0);
        chk("tag4_val", 64'(commit_val), 64'h77);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 7, 32'h300, 1, 1, 32'h33, 0, 0, 1);
        chk("hold_count",  64'(count),        64'd2);
        chk("hold_cvalid", 64'(commit_valid), 64'd1);
        chk("hold_cval",   64'(commit_val),   64'h77);
        rdy = 1'b1;

        // Flush with three busy entries and a concurrent write-back
        drive(1, 6, 32'h114, 0, 0, 0, 0, 0, 0);
        chk("pre_flush_count", 64'(count), 64'd3);
        flush = 1'b1;
        drive(1, 8, 32'h118, 1, 1, 5, 0, 0, 1);
        flush = 1'b0;
        chk("flush_count",  64'(count),        64'd0);
        chk("flush_empty",  64'(rob_empty),    64'd1);
        chk("flush_tag",    64'(push_tag),     64'd1);
        chk("flush_cvalid", 64'(commit_valid), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            drive(int'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 7)), int'($urandom),
                  int'($urandom_range(0, 1)));
        end
        rdy   = 1'b1;
        flush = 1'b0;

        // Asynchronous reset between clock edges
        idle();
        drive(1, 3, 32'h400, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, int'(push_tag == 0 ? 1 : 1), 32'h5A, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        chk("post_rst_count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
